// File: rtl/rst_ctrl_pkg.sv
// Shared types and sizing helpers for the core reset / push-button conditioner.
package rst_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HOLD        = 3'd0,
    S_IDLE        = 3'd1,
    S_PRESS_CHK   = 3'd2,
    S_PRESSED     = 3'd3,
    S_RELEASE_CHK = 3'd4
  } state_t;

  // One counter serves both the debounce window and the reset stretch.
  function automatic int cnt_width(input int debounce_cycles, input int hold_cycles);
    int max_cycles;
    max_cycles = (debounce_cycles > hold_cycles) ? debounce_cycles : hold_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/rst_ctrl_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clock edge.
module rst_sync (
  input  logic clk,
  input  logic rst_n_in,
  output logic rst_n_out
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_out = sync_q[1];

endmodule

// File: rtl/rst_ctrl.sv
// Turns the raw centre button and the power-on/lock reset into a clean, stretched core reset
// plus a debounced button level and a single-cycle press pulse.
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 750000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rst,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, RST_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   rst_n_s;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_d;
  logic                   btn_s;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   rst_q;
  logic                   btn_level_q;
  logic                   btn_press_q;

  rst_sync u_rst_sync (
    .clk       (clk),
    .rst_n_in  (rst_n),
    .rst_n_out (rst_n_s)
  );

  // Bit 0 samples the pad; the top bit is the metastability-safe level.
  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      btn_sync_q <= '0;
    end else begin
      btn_sync_q <= btn_sync_d;
    end
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];

  // Saturating increment so a long dwell can never wrap into a false match.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      rst_q       <= 1'b1;
      btn_level_q <= 1'b0;
      btn_press_q <= 1'b0;
    end else begin
      btn_press_q <= 1'b0;
      case (state_q)
        S_HOLD: begin
          rst_q       <= 1'b1;
          btn_level_q <= 1'b0;
          if (cnt_q == HOLD_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_IDLE: begin
          rst_q <= 1'b0;
          if (btn_s) begin
            state_q <= S_PRESS_CHK;
            cnt_q   <= '0;
          end
        end
        S_PRESS_CHK: begin
          if (!btn_s) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= S_PRESSED;
            cnt_q       <= '0;
            rst_q       <= 1'b1;
            btn_level_q <= 1'b1;
            btn_press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_PRESSED: begin
          rst_q       <= 1'b1;
          btn_level_q <= 1'b1;
          if (!btn_s) begin
            state_q <= S_RELEASE_CHK;
            cnt_q   <= '0;
          end
        end
        S_RELEASE_CHK: begin
          if (btn_s) begin
            state_q <= S_PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= S_HOLD;
          cnt_q   <= '0;
          rst_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rst       = rst_q;
  assign btn_level = btn_level_q;
  assign btn_press = btn_press_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed bench for rst_ctrl: power-on stretch, press/release debounce, bounce and glitch rejection,
// and reset asserted in the middle of a debounce.
module tb_rst_ctrl;

  logic clk;
  logic rst_n;
  logic btn_raw;
  logic rst;
  logic btn_level;
  logic btn_press;

  int compared;
  int mismatched;

  rst_ctrl #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .rst       (rst),
    .btn_level (btn_level),
    .btn_press (btn_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one active edge and settle; inputs changed after this land before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    #2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = 3'b100;
      compared++;
      if ({rst, btn_level, btn_press} !== exp) begin
        mismatched++;
        $display("FAIL reset_hold k=%0d got=%b want=%b", k, {rst, btn_level, btn_press}, exp);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k < 5) ? 3'b100 : 3'b000;
      compared++;
      if ({rst, btn_level, btn_press} !== exp) begin
        mismatched++;
        $display("FAIL power_on k=%0d got=%b want=%b", k, {rst, btn_level, btn_press}, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp;
    btn_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k == 7) ? 3'b111 : ((k > 7) ? 3'b110 : 3'b000);
      compared++;
      if ({rst, btn_level, btn_press} !== exp) begin
        mismatched++;
        $display("FAIL clean_press k=%0d got=%b want=%b", k, {rst, btn_level, btn_press}, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [2:0] exp;
    btn_raw = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp = {(k < 10), (k < 7), 1'b0};
      compared++;
      if ({rst, btn_level, btn_press} !== exp) begin
        mismatched++;
        $display("FAIL release k=%0d got=%b want=%b", k, {rst, btn_level, btn_press}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 30; i++) begin
      btn_raw = (i % 3 != 2);
      tick();
      compared++;
      if ({rst, btn_level, btn_press} !== 3'b000) begin
        mismatched++;
        $display("FAIL bounce i=%0d got=%b want=000", i, {rst, btn_level, btn_press});
      end
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      compared++;
      if ({rst, btn_level, btn_press} !== 3'b000) begin
        mismatched++;
        $display("FAIL bounce_tail k=%0d got=%b want=000", k, {rst, btn_level, btn_press});
      end
    end
  endtask

  task automatic test_release_glitch();
    logic [2:0] exp;
    btn_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k == 7) ? 3'b111 : ((k > 7) ? 3'b110 : 3'b000);
      compared++;
      if ({rst, btn_level, btn_press} !== exp) begin
        mismatched++;
        $display("FAIL glitch_press k=%0d got=%b want=%b", k, {rst, btn_level, btn_press}, exp);
      end
    end
    for (int k = 1; k <= 15; k++) begin
      btn_raw = (k > 2);
      tick();
      compared++;
      if ({rst, btn_level, btn_press} !== 3'b110) begin
        mismatched++;
        $display("FAIL release_glitch k=%0d got=%b want=110", k, {rst, btn_level, btn_press});
      end
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    compared++;
    if ({rst, btn_level, btn_press} !== 3'b000) begin
      mismatched++;
      $display("FAIL glitch_cleanup got=%b want=000", {rst, btn_level, btn_press});
    end
  endtask

  task automatic test_mid_debounce_reset();
    logic [2:0] exp;
    int presses;
    btn_raw = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 1'b0;
    #1;
    compared++;
    if ({rst, btn_level, btn_press} !== 3'b100) begin
      mismatched++;
      $display("FAIL async_assert got=%b want=100", {rst, btn_level, btn_press});
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      compared++;
      if ({rst, btn_level, btn_press} !== 3'b100) begin
        mismatched++;
        $display("FAIL mid_reset_hold k=%0d got=%b want=100", k, {rst, btn_level, btn_press});
      end
    end
    rst_n   = 1'b1;
    presses = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (btn_press) presses++;
      if (k < 5)       exp = 3'b100;
      else if (k < 10) exp = 3'b000;
      else if (k == 10) exp = 3'b111;
      else             exp = 3'b110;
      compared++;
      if ({rst, btn_level, btn_press} !== exp) begin
        mismatched++;
        $display("FAIL mid_debounce_reset k=%0d got=%b want=%b", k, {rst, btn_level, btn_press}, exp);
      end
    end
    compared++;
    if (presses !== 1) begin
      mismatched++;
      $display("FAIL press_count got=%0d want=1", presses);
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    compared++;
    if ({rst, btn_level, btn_press} !== 3'b000) begin
      mismatched++;
      $display("FAIL final_idle got=%b want=000", {rst, btn_level, btn_press});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    btn_raw    = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release_glitch();
    test_mid_debounce_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
